// File: rtl/mfe_pkg.sv
// -----------------------------------------------------------------------------
// mfe_pkg
// Shared definitions for the median-filter engine (MFE) and its image loader.
//   - Frame geometry constants (IMG_W, IMG_H) and bus widths (AW, DW, CKW).
//   - Loader state encoding (S_LOAD, S_HANDOFF, S_RUN, S_DONE).
//   - pack_xy(): the {x,y} image-memory address packing. The engine uses the
//     same function, so both sides agree on the memory layout.
// No ports (package).
// -----------------------------------------------------------------------------
package mfe_pkg;

   localparam int unsigned IMG_W = 128;
   localparam int unsigned IMG_H = 128;
   localparam int unsigned XW    = $clog2(IMG_W);
   localparam int unsigned YW    = $clog2(IMG_H);
   localparam int unsigned AW    = 14;
   localparam int unsigned DW    = 8;
   localparam int unsigned CKW   = 16;

   typedef enum logic [1:0] {
      S_LOAD    = 2'd0,
      S_HANDOFF = 2'd1,
      S_RUN     = 2'd2,
      S_DONE    = 2'd3
   } loader_state_e;

   // Address = x*IMG_H + y: column-major storage, x in the upper bits.
   function automatic logic [AW-1:0] pack_xy(input logic [XW-1:0] x, input logic [YW-1:0] y);
      return {x, y};
   endfunction

endpackage

// File: rtl/mfe_xy_counter.sv
// -----------------------------------------------------------------------------
// mfe_xy_counter
// Raster-order x/y pixel counter: x advances fastest, wraps at NX-1 and
// carries into y; y wraps at NY-1 back to 0, so the last pixel returns the
// counter to (0,0).
// Ports:
//   clk, reset      clock, asynchronous active-low reset (to 0,0)
//   clear           synchronous clear to (0,0)            (highest priority)
//   load_one        synchronous load to (1,0)             (frame resync)
//   inc             advance one pixel in raster order
//   x, y            current position
//   last            position is (NX-1, NY-1)
//   origin          position is (0,0)
// -----------------------------------------------------------------------------
module mfe_xy_counter #(
   parameter int unsigned NX = 128,
   parameter int unsigned NY = 128,
   parameter int unsigned XW = $clog2(NX),
   parameter int unsigned YW = $clog2(NY)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clear,
   input  logic          load_one,
   input  logic          inc,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          last,
   output logic          origin
);

   localparam logic [XW-1:0] XMAX = XW'(NX - 1);
   localparam logic [YW-1:0] YMAX = YW'(NY - 1);

   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;

   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clear) begin
         x_d = '0;
         y_d = '0;
      end else if (load_one) begin
         // The resync pixel itself occupies (0,0); the next one is (1,0).
         x_d = XW'(1);
         y_d = '0;
      end else if (inc) begin
         if (x_q == XMAX) begin
            x_d = '0;
            y_d = (y_q == YMAX) ? '0 : y_q + 1'b1;
         end else begin
            x_d = x_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_q <= '0;
         y_q <= '0;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign x      = x_q;
   assign y      = y_q;
   assign last   = (x_q == XMAX) && (y_q == YMAX);
   assign origin = (x_q == '0) && (y_q == '0);

endmodule

// File: rtl/mfe_img_loader.sv
// -----------------------------------------------------------------------------
// mfe_img_loader
// Upstream feeder for the median-filter engine. Accepts a raster-order
// grayscale pixel stream (valid/ready), writes each pixel into the image
// memory at pack_xy(x,y), and once a full IMG_W x IMG_H frame is stored hands
// the memory to the engine (mfe_ready / mfe_busy), pulses frame_done when the
// engine finishes, then re-opens the stream.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   s_valid/s_ready       stream handshake; beat = s_valid && s_ready
//   s_data [DW]           pixel value
//   s_sof                 first pixel of a frame; forces resync to (0,0)
//   iaddr_w/idata_w/iwen  registered image-memory write port
//   mfe_ready             engine start request
//   mfe_busy              engine busy status
//   frame_done            one-cycle pulse after the engine completes
//   sof_err               one-cycle pulse when s_sof arrives off (0,0)
//   cksum [16]            frame pixel sum (only with LOADER_CKSUM_EN)
//
// Build option: define LOADER_CKSUM_EN to enable the 16-bit wrapping frame
// checksum; otherwise cksum is tied to 0.
// -----------------------------------------------------------------------------
module mfe_img_loader
   import mfe_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [DW-1:0]  s_data,
   input  logic           s_sof,
   output logic [AW-1:0]  iaddr_w,
   output logic [DW-1:0]  idata_w,
   output logic           iwen,
   output logic           mfe_ready,
   input  logic           mfe_busy,
   output logic           frame_done,
   output logic           sof_err,
   output logic [CKW-1:0] cksum
);

   loader_state_e state_q, state_d;

   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          last_px;
   logic          origin;

   logic          beat;
   logic          resync;

   logic          s_ready_q, s_ready_d;
   logic          mfe_ready_q, mfe_ready_d;
   logic          frame_done_q, frame_done_d;
   logic          sof_err_q;
   logic          iwen_q;
   logic [AW-1:0] iaddr_q;
   logic [DW-1:0] idata_q;

   // s_ready_q is only ever set while in S_LOAD, so beats cannot occur elsewhere.
   assign beat   = s_valid & s_ready_q;
   assign resync = beat & s_sof & ~origin;

   mfe_xy_counter #(
      .NX (IMG_W),
      .NY (IMG_H),
      .XW (XW),
      .YW (YW)
   ) u_xy_counter (
      .clk      (clk),
      .reset    (reset),
      .clear    (1'b0),
      .load_one (resync),
      .inc      (beat & ~resync),
      .x        (x),
      .y        (y),
      .last     (last_px),
      .origin   (origin)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_LOAD:    if (beat && !resync && last_px) state_d = S_HANDOFF;
         S_HANDOFF: if (mfe_busy)                   state_d = S_RUN;
         S_RUN:     if (!mfe_busy)                  state_d = S_DONE;
         S_DONE:                                    state_d = S_LOAD;
         default:                                   state_d = S_LOAD;
      endcase

      // Ready only after a full cycle in S_LOAD: drops right after the last
      // beat and returns the cycle after frame_done.
      s_ready_d    = (state_q == S_LOAD) && (state_d == S_LOAD);
      // Raised one cycle after entering S_HANDOFF so the final write has landed.
      mfe_ready_d  = (state_q == S_HANDOFF) && !mfe_busy;
      frame_done_d = (state_q == S_DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_LOAD;
         s_ready_q    <= 1'b0;
         mfe_ready_q  <= 1'b0;
         frame_done_q <= 1'b0;
         sof_err_q    <= 1'b0;
         iwen_q       <= 1'b0;
         iaddr_q      <= '0;
         idata_q      <= '0;
      end else begin
         state_q      <= state_d;
         s_ready_q    <= s_ready_d;
         mfe_ready_q  <= mfe_ready_d;
         frame_done_q <= frame_done_d;
         sof_err_q    <= resync;
         iwen_q       <= beat;
         if (beat) begin
            iaddr_q <= resync ? '0 : pack_xy(x, y);
            idata_q <= s_data;
         end
      end
   end

`ifdef LOADER_CKSUM_EN
   logic [CKW-1:0] cksum_q;

   // Only changes on beats, so it is frozen from S_HANDOFF until the next
   // frame's first pixel restarts it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cksum_q <= '0;
      end else if (beat) begin
         if (origin || s_sof) begin
            cksum_q <= CKW'(s_data);
         end else begin
            cksum_q <= cksum_q + CKW'(s_data);
         end
      end
   end

   assign cksum = cksum_q;
`else
   assign cksum = '0;
`endif

   assign s_ready    = s_ready_q;
   assign mfe_ready  = mfe_ready_q;
   assign frame_done = frame_done_q;
   assign sof_err    = sof_err_q;
   assign iwen       = iwen_q;
   assign iaddr_w    = iaddr_q;
   assign idata_w    = idata_q;

endmodule

// File: tb/tb_mfe_img_loader.sv
// -----------------------------------------------------------------------------
// tb_mfe_img_loader
// Self-checking bench for mfe_img_loader: a directed vector table for the
// first-pixel / resync address behaviour, then full-frame sequences covering
// streaming, engine hand-off, stall, resync mid-frame, checksum and reset.
// Honours LOADER_CKSUM_EN for the expected checksum.
// -----------------------------------------------------------------------------
module tb_mfe_img_loader;

   logic        clk;
   logic        reset;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        s_sof;
   logic [13:0] iaddr_w;
   logic [7:0]  idata_w;
   logic        iwen;
   logic        mfe_ready;
   logic        mfe_busy;
   logic        frame_done;
   logic        sof_err;
   logic [15:0] cksum;

`ifdef LOADER_CKSUM_EN
   localparam logic [15:0] CK_ALL_FF = 16'hC000;
`else
   localparam logic [15:0] CK_ALL_FF = 16'h0000;
`endif

   int checks   = 0;
   int failures = 0;

   mfe_img_loader dut (
      .clk        (clk),
      .reset      (reset),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_sof      (s_sof),
      .iaddr_w    (iaddr_w),
      .idata_w    (idata_w),
      .iwen       (iwen),
      .mfe_ready  (mfe_ready),
      .mfe_busy   (mfe_busy),
      .frame_done (frame_done),
      .sof_err    (sof_err),
      .cksum      (cksum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Image memory model and protocol monitor (sole writer of these variables).
   logic [7:0] mem   [16384];
   int         stamp [16384];
   int         cyc       = 0;
   int         iwen_cnt  = 0;
   int         iwen_bad  = 0;
   int         fd_cnt    = 0;
   int         err_cnt   = 0;
   int         ck_nz     = 0;
   logic       prev_beat = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset) begin
         prev_beat <= 1'b0;
      end else begin
         if (iwen) begin
            mem[iaddr_w]   <= idata_w;
            stamp[iaddr_w] <= cyc;
            iwen_cnt       <= iwen_cnt + 1;
         end
         // A write must follow exactly one cycle after each accepted beat.
         if (iwen !== prev_beat) iwen_bad <= iwen_bad + 1;
         if (frame_done)         fd_cnt   <= fd_cnt + 1;
         if (sof_err)            err_cnt  <= err_cnt + 1;
         if (cksum != 16'h0)     ck_nz    <= ck_nz + 1;
         prev_beat <= s_valid & s_ready;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!s_ready && n < 8) begin
         tick();
         n++;
      end
      check(name, 32'(s_ready), 32'd1);
   endtask

   task automatic send_pixel(input logic [7:0] d, input logic sof, input bit gaps);
      bit done  = 1'b0;
      int guard = 0;
      while (!done) begin
         s_data  = d;
         s_sof   = sof;
         s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         done    = s_valid && s_ready;
         tick();
         guard++;
         if (guard > 1000) begin
            $display("FAIL send_pixel_timeout: s_ready stuck at %0d, expected 1", s_ready);
            $fatal(1, "stream stalled");
         end
      end
      s_valid = 1'b0;
      s_sof   = 1'b0;
   endtask

   task automatic check_mem(input string name, input int since, input bit all_ff);
      int bad = 0;
      for (int y = 0; y < 128; y++) begin
         for (int x = 0; x < 128; x++) begin
            logic [7:0] e;
            int         a;
            e = all_ff ? 8'hFF : 8'(x + y);
            a = x * 128 + y;
            if (mem[a] !== e || !(stamp[a] > since)) bad++;
         end
      end
      check(name, 32'(bad), 32'd0);
   endtask

   // Called in the cycle after the last beat of a frame.
   task automatic finish_frame(input bit busy_early, input bit chk_ck, input logic [15:0] exp_ck);
      int w0;
      int f0;
      int bad = 0;
      check("last_write_iwen", 32'(iwen), 32'd1);
      check("s_ready_drop", 32'(s_ready), 32'd0);
      check("mfe_ready_k1", 32'(mfe_ready), 32'd0);
      // Keep offering data through the hand-off: it must stall.
      s_valid = 1'b1;
      s_sof   = 1'b0;
      s_data  = 8'h5A;
      tick();
      w0 = iwen_cnt;
      f0 = fd_cnt;
      if (!busy_early) begin
         check("mfe_ready_rise", 32'(mfe_ready), 32'd1);
         check("iwen_after_last", 32'(iwen), 32'd0);
         repeat (3) tick();
         mfe_busy = 1'b1;
         tick();
         check("mfe_ready_fall", 32'(mfe_ready), 32'd0);
         repeat (99) begin
            if (s_ready || frame_done || mfe_ready) bad++;
            tick();
         end
      end else begin
         check("mfe_ready_busy_early", 32'(mfe_ready), 32'd0);
         repeat (5) begin
            if (s_ready || frame_done || mfe_ready) bad++;
            tick();
         end
      end
      mfe_busy = 1'b0;
      tick();
      check("frame_done_early", 32'(frame_done), 32'd0);
      s_valid = 1'b0;
      tick();
      check("frame_done_pulse", 32'(frame_done), 32'd1);
      check("s_ready_in_done", 32'(s_ready), 32'd0);
      if (chk_ck) check("cksum_at_done", 32'(cksum), 32'(exp_ck));
      tick();
      check("frame_done_clear", 32'(frame_done), 32'd0);
      check("s_ready_return", 32'(s_ready), 32'd1);
      check("handoff_no_writes", 32'(iwen_cnt - w0), 32'd0);
      check("frame_done_count", 32'(fd_cnt - f0), 32'd1);
      check("handoff_hold", 32'(bad), 32'd0);
   endtask

   typedef struct {
      logic        v;
      logic        sof;
      logic [7:0]  d;
      logic        e_iwen;
      logic [13:0] e_addr;
      logic        e_err;
   } vec_t;

   vec_t vecs [9];

   initial begin
      int since;
      int w0;
      int e0;

      // Vectors applied from (0,0); outputs checked the following cycle.
      vecs[0] = '{1'b1, 1'b1, 8'h11, 1'b1, 14'h000, 1'b0}; // sof at origin: no error
      vecs[1] = '{1'b1, 1'b0, 8'h22, 1'b1, 14'h080, 1'b0}; // x=1,y=0
      vecs[2] = '{1'b0, 1'b0, 8'h33, 1'b0, 14'h000, 1'b0}; // idle
      vecs[3] = '{1'b1, 1'b0, 8'h44, 1'b1, 14'h100, 1'b0}; // x=2
      vecs[4] = '{1'b1, 1'b1, 8'h55, 1'b1, 14'h000, 1'b1}; // resync at x=3
      vecs[5] = '{1'b1, 1'b0, 8'h66, 1'b1, 14'h080, 1'b0}; // continues at (1,0)
      vecs[6] = '{1'b1, 1'b1, 8'h77, 1'b1, 14'h000, 1'b1}; // resync at x=2
      vecs[7] = '{1'b0, 1'b1, 8'h88, 1'b0, 14'h000, 1'b0}; // sof without valid
      vecs[8] = '{1'b1, 1'b0, 8'h99, 1'b1, 14'h080, 1'b0};

      reset    = 1'b1;
      s_valid  = 1'b0;
      s_sof    = 1'b0;
      s_data   = 8'h00;
      mfe_busy = 1'b0;
      #1 reset = 1'b0;
      #1;
      check("rst_s_ready", 32'(s_ready), 32'd0);
      check("rst_iwen", 32'(iwen), 32'd0);
      check("rst_iaddr", 32'(iaddr_w), 32'd0);
      check("rst_idata", 32'(idata_w), 32'd0);
      check("rst_mfe_ready", 32'(mfe_ready), 32'd0);
      check("rst_frame_done", 32'(frame_done), 32'd0);
      check("rst_sof_err", 32'(sof_err), 32'd0);
      check("rst_cksum", 32'(cksum), 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      wait_ready("ready_after_reset");

      for (int i = 0; i < 9; i++) begin
         s_valid = vecs[i].v;
         s_sof   = vecs[i].sof;
         s_data  = vecs[i].d;
         tick();
         s_valid = 1'b0;
         s_sof   = 1'b0;
         check($sformatf("vec%0d_iwen", i), 32'(iwen), 32'(vecs[i].e_iwen));
         check($sformatf("vec%0d_sof_err", i), 32'(sof_err), 32'(vecs[i].e_err));
         if (vecs[i].e_iwen) begin
            check($sformatf("vec%0d_addr", i), 32'(iaddr_w), 32'(vecs[i].e_addr));
            check($sformatf("vec%0d_data", i), 32'(idata_w), 32'(vecs[i].d));
         end
      end

      // Clean restart before the full frames.
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      wait_ready("ready_after_rst2");

      // Frame A: continuous valid, pixel = (x+y), engine busy 3 cycles after ready.
      since = cyc;
      w0    = iwen_cnt;
      for (int y = 0; y < 128; y++)
         for (int x = 0; x < 128; x++)
            send_pixel(8'(x + y), (x == 0 && y == 0), 1'b0);
      finish_frame(1'b0, 1'b0, 16'h0);
      check("frameA_write_count", 32'(iwen_cnt - w0), 32'd16384);
      check_mem("frameA_mem", since, 1'b0);

      // Frame B: ~50% valid duty; engine already busy when hand-off begins.
      since = cyc;
      for (int y = 0; y < 128; y++)
         for (int x = 0; x < 128; x++) begin
            if (x == 127 && y == 127) mfe_busy = 1'b1;
            send_pixel(8'(x + y), (x == 0 && y == 0), 1'b1);
         end
      finish_frame(1'b1, 1'b0, 16'h0);
      check_mem("frameB_mem", since, 1'b0);

      // Frame C: all 0xFF, sof repeated on pixel 300 forces a resync.
      since = cyc;
      e0    = err_cnt;
      for (int i = 0; i < 300; i++) send_pixel(8'hFF, (i == 0), 1'b0);
      send_pixel(8'hFF, 1'b1, 1'b0);
      check("resync_addr", 32'(iaddr_w), 32'h0000);
      check("resync_err", 32'(sof_err), 32'd1);
      send_pixel(8'hFF, 1'b0, 1'b0);
      check("resync_next_addr", 32'(iaddr_w), 32'h0080);
      check("resync_err_clear", 32'(sof_err), 32'd0);
      for (int i = 2; i < 16383; i++) send_pixel(8'hFF, 1'b0, 1'b0);
      check("resync_not_done_early", 32'(s_ready), 32'd1);
      send_pixel(8'hFF, 1'b0, 1'b0);
      finish_frame(1'b0, 1'b1, CK_ALL_FF);
      check("resync_err_count", 32'(err_cnt - e0), 32'd1);
      check_mem("frameC_mem", since, 1'b1);

      // Reset in the middle of a frame, then a fresh first pixel.
      for (int i = 0; i < 5000; i++) send_pixel(8'((i % 128) + (i / 128)), (i == 0), 1'b0);
      reset = 1'b0;
      #1;
      check("midrst_s_ready", 32'(s_ready), 32'd0);
      check("midrst_iwen", 32'(iwen), 32'd0);
      check("midrst_iaddr", 32'(iaddr_w), 32'd0);
      check("midrst_idata", 32'(idata_w), 32'd0);
      check("midrst_mfe_ready", 32'(mfe_ready), 32'd0);
      check("midrst_frame_done", 32'(frame_done), 32'd0);
      check("midrst_sof_err", 32'(sof_err), 32'd0);
      check("midrst_cksum", 32'(cksum), 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      wait_ready("ready_after_midrst");
      send_pixel(8'hAB, 1'b0, 1'b0);
      check("post_rst_iwen", 32'(iwen), 32'd1);
      check("post_rst_addr", 32'(iaddr_w), 32'h0000);
      check("post_rst_data", 32'(idata_w), 32'h00AB);
      check("post_rst_err", 32'(sof_err), 32'd0);
      tick();

      check("iwen_protocol", 32'(iwen_bad), 32'd0);
`ifndef LOADER_CKSUM_EN
      check("cksum_tied_zero", 32'(ck_nz), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
